// File: rtl/syn_ram_pkg.sv
// Shared definitions for the syn_ram storage primitive.
// Optional build macro: SYN_RAM_PARITY_EN (adds a stored even-parity bit).
package syn_ram_pkg;

  localparam int DEF_DATA_W = 2;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DEPTH  = 16;

  // CLEAR sweeps zeros into the array after reset; READY serves the ports.
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_e;

  // Even parity: the returned bit makes the total count of ones even.
  // Callers zero-extend their word to 64 bits, which leaves the result unchanged.
  function automatic logic even_par(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/syn_ram_if.sv
// Port bundle for syn_ram_dp: write port, read port, output enable and status.
// Optional build macro: SYN_RAM_PARITY_EN (adds par_inj / par_err).
interface syn_ram_if #(
  parameter int DATA_W = syn_ram_pkg::DEF_DATA_W,
  parameter int ADDR_W = syn_ram_pkg::DEF_ADDR_W
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] din;
  logic              re;
  logic [ADDR_W-1:0] raddr;
  logic              oe;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              init_busy;
`ifdef SYN_RAM_PARITY_EN
  logic              par_inj;
  logic              par_err;

  modport master (
    output we, waddr, din, re, raddr, oe, par_inj,
    input  dout, dout_valid, init_busy, par_err
  );
  modport slave (
    input  we, waddr, din, re, raddr, oe, par_inj,
    output dout, dout_valid, init_busy, par_err
  );
`else
  modport master (
    output we, waddr, din, re, raddr, oe,
    input  dout, dout_valid, init_busy
  );
  modport slave (
    input  we, waddr, din, re, raddr, oe,
    output dout, dout_valid, init_busy
  );
`endif
endinterface

// File: rtl/syn_ram_clr_ctrl.sv
// Post-reset clear sequencer: walks ptr over 0..DEPTH-1 writing zeros,
// holding init_busy high until the last word has been written.
module syn_ram_clr_ctrl
  import syn_ram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  output logic              init_busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              init_busy_q, init_busy_d;

  // Next-state: advance the sweep pointer, leave CLEAR after the last word.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    init_busy_d = init_busy_q;
    if (state_q == CLEAR) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == LAST) begin
        state_d     = READY;
        init_busy_d = 1'b0;
        ptr_d       = '0;
      end
    end
  end

  // FSM registers; reset restarts the sweep from word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR;
      ptr_q       <= '0;
      init_busy_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      init_busy_q <= init_busy_d;
    end
  end

  // No clear write on a reset cycle: the sweep only runs with rst low.
  assign clr_we    = (state_q == CLEAR) && !rst;
  assign clr_addr  = ptr_q;
  assign init_busy = init_busy_q;

endmodule

// File: rtl/syn_ram_dp.sv
// Simple dual-port synchronous RAM: one write port, one registered read port,
// single clock, hardware clear sweep after reset, write-first on collision.
// Optional build macro: SYN_RAM_PARITY_EN (stores an even-parity bit per word,
// par_inj flips it on write, par_err flags a mismatch on read).
module syn_ram_dp
  import syn_ram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic     clk,
  input  logic     rst,
  syn_ram_if.slave bus
);

`ifdef SYN_RAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  logic [MEM_W-1:0]  mem_q [DEPTH];

  logic              init_busy;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  logic              ready;
  logic              port_wr;
  logic              rd_fire;
  logic              rd_in_range;
  logic [MEM_W-1:0]  wr_word;
  logic [MEM_W-1:0]  rd_word;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [MEM_W-1:0]  mem_wdata;

  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
`ifdef SYN_RAM_PARITY_EN
  logic              par_err_q, par_err_d;
`endif

  syn_ram_clr_ctrl #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clr_ctrl (
    .clk       (clk),
    .rst       (rst),
    .init_busy (init_busy),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr)
  );

  // Ports are live only once the sweep has finished and reset is low.
  assign ready       = !init_busy && !rst;
  assign port_wr     = ready && bus.we && (32'(bus.waddr) < DEPTH);
  assign rd_fire     = ready && bus.re;
  assign rd_in_range = 32'(bus.raddr) < DEPTH;

`ifdef SYN_RAM_PARITY_EN
  assign wr_word = {even_par(64'(bus.din)) ^ bus.par_inj, bus.din};
`else
  assign wr_word = bus.din;
`endif

  // Array write source: the clear sweep and the port are never active together.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (clr_we) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr;
    end else if (port_wr) begin
      mem_we    = 1'b1;
      mem_waddr = bus.waddr;
      mem_wdata = wr_word;
    end
  end

  // Storage array; contents are not reset, the sweep zeroes them.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  // Read word: out-of-range reads give 0, a same-edge write to the same word wins.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      if (port_wr && (bus.waddr == bus.raddr)) rd_word = wr_word;
      else                                     rd_word = mem_q[bus.raddr];
    end
  end

  // Read register next-state: load on a read, otherwise hold dout and drop valid.
  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = rd_fire;
    if (rd_fire) dout_d = rd_word[DATA_W-1:0];
`ifdef SYN_RAM_PARITY_EN
    par_err_d = rd_fire &&
                (rd_word[DATA_W] != even_par(64'(rd_word[DATA_W-1:0])));
`endif
  end

  // Read output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
`ifdef SYN_RAM_PARITY_EN
      par_err_q    <= 1'b0;
`endif
    end else begin
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
`ifdef SYN_RAM_PARITY_EN
      par_err_q    <= par_err_d;
`endif
    end
  end

  // oe only masks the visible data, never the register or the valid flag.
  assign bus.dout       = bus.oe ? dout_q : '0;
  assign bus.dout_valid = dout_valid_q;
  assign bus.init_busy  = init_busy;
`ifdef SYN_RAM_PARITY_EN
  assign bus.par_err    = par_err_q;
`endif

endmodule

// File: tb/tb_syn_ram_dp.sv
// Directed bench for syn_ram_dp: a DEPTH=16 instance for sweep, read/write,
// collision, oe and mid-sweep reset, and a DEPTH=12 instance for bounds.
module tb_syn_ram_dp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  syn_ram_if #(.DATA_W(2), .ADDR_W(4)) bus16 ();
  syn_ram_if #(.DATA_W(2), .ADDR_W(4)) bus12 ();

  syn_ram_dp #(.DATA_W(2), .ADDR_W(4), .DEPTH(16)) u_dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  syn_ram_dp #(.DATA_W(2), .ADDR_W(4), .DEPTH(12)) u_dut12 (
    .clk (clk),
    .rst (rst),
    .bus (bus12)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr16(input logic [3:0] a, input logic [1:0] d);
    bus16.we = 1'b1; bus16.waddr = a; bus16.din = d;
    tick();
    bus16.we = 1'b0;
  endtask

  task automatic rd16(input logic [3:0] a, input logic [1:0] exp, input string tag);
    bus16.re = 1'b1; bus16.raddr = a;
    tick();
    bus16.re = 1'b0;
    chk({tag, "_vld"}, 32'(bus16.dout_valid), 32'd1);
    chk(tag, 32'(bus16.dout), 32'(exp));
  endtask

  // Counts edges until each instance drops init_busy (bounded), and counts
  // any dout_valid seen while busy. Port requests on bus16 stop once ready.
  task automatic count_busy(output int n16, output int n12, output int vcnt);
    n16 = -1; n12 = -1; vcnt = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bus16.init_busy && bus16.dout_valid) vcnt++;
      if (bus12.init_busy && bus12.dout_valid) vcnt++;
      if (n16 < 0 && !bus16.init_busy) begin
        n16 = i; bus16.we = 1'b0; bus16.re = 1'b0;
      end
      if (n12 < 0 && !bus12.init_busy) n12 = i;
      if (n16 >= 0 && n12 >= 0) break;
    end
  endtask

  int n16, n12, vcnt;
  logic busy_seen;

  initial begin
    bus16.we = 0; bus16.waddr = 0; bus16.din = 0; bus16.re = 0; bus16.raddr = 0; bus16.oe = 1;
    bus12.we = 0; bus12.waddr = 0; bus12.din = 0; bus12.re = 0; bus12.raddr = 0; bus12.oe = 1;
`ifdef SYN_RAM_PARITY_EN
    bus16.par_inj = 0; bus12.par_inj = 0;
`endif

    // Reset state
    tick(); tick();
    chk("rst_busy",  32'(bus16.init_busy),  32'd1);
    chk("rst_vld",   32'(bus16.dout_valid), 32'd0);
    chk("rst_dout",  32'(bus16.dout),       32'd0);
    chk("rst_busy12",32'(bus12.init_busy),  32'd1);

    // First sweep length
    rst = 1'b0;
    count_busy(n16, n12, vcnt);
    chk("sweep0_len16", 32'(n16), 32'd16);
    chk("sweep0_len12", 32'(n12), 32'd12);

    // Fill with 11, reset pulse, sweep must clear everything
    for (int a = 0; a < 16; a++) wr16(4'(a), 2'b11);
    rd16(4'd15, 2'b11, "fill15");
    rst = 1'b1; tick(); rst = 1'b0;
    count_busy(n16, n12, vcnt);
    chk("sweep1_len16", 32'(n16), 32'd16);
    chk("sweep1_len12", 32'(n12), 32'd12);
    chk("sweep1_novld", 32'(vcnt), 32'd0);
    for (int a = 0; a < 16; a++) rd16(4'(a), 2'b00, $sformatf("clr%0d", a));

    // Basic write/read, then valid drops and dout holds
    wr16(4'd3, 2'b10);
    wr16(4'd7, 2'b01);
    rd16(4'd3, 2'b10, "rd3");
    rd16(4'd7, 2'b01, "rd7");
    tick();
    chk("idle_vld",  32'(bus16.dout_valid), 32'd0);
    chk("idle_hold", 32'(bus16.dout),       32'd1);

    // Same-address collision is write-first
    wr16(4'd5, 2'b01);
    bus16.we = 1; bus16.waddr = 5; bus16.din = 2'b10;
    bus16.re = 1; bus16.raddr = 5;
    tick();
    bus16.we = 0; bus16.re = 0;
    chk("coll_vld",  32'(bus16.dout_valid), 32'd1);
    chk("coll_dout", 32'(bus16.dout),       32'd2);
    rd16(4'd5, 2'b10, "coll_stored");

    // oe masks dout only
    bus16.oe = 1'b0;
    rd16(4'd3, 2'b00, "oe0");
    bus16.oe = 1'b1;
    #1;
    chk("oe1", 32'(bus16.dout), 32'd2);

    // Bounds on DEPTH=12
    bus12.we = 1; bus12.waddr = 1;  bus12.din = 2'b10; tick();
    bus12.waddr = 13; bus12.din = 2'b01; tick();
    bus12.waddr = 11; bus12.din = 2'b11; tick();
    bus12.we = 0;
    bus12.re = 1; bus12.raddr = 13; tick();
    chk("oob_vld",  32'(bus12.dout_valid), 32'd1);
    chk("oob_dout", 32'(bus12.dout),       32'd0);
    bus12.raddr = 1; tick();
    chk("noalias1", 32'(bus12.dout), 32'd2);
    bus12.raddr = 11; tick();
    chk("last11",   32'(bus12.dout), 32'd3);
    bus12.re = 0;

    // Reset mid-sweep with port traffic held active during the sweep
    bus16.we = 1; bus16.waddr = 0; bus16.din = 2'b11;
    bus16.re = 1; bus16.raddr = 0;
    rst = 1'b1; tick(); rst = 1'b0;
    busy_seen = 1'b1; vcnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (!bus16.init_busy) busy_seen = 1'b0;
      if (bus16.dout_valid) vcnt++;
    end
    chk("mid_busy8", 32'(busy_seen), 32'd1);
    chk("mid_novld8", 32'(vcnt), 32'd0);
    rst = 1'b1; tick(); rst = 1'b0;
    count_busy(n16, n12, vcnt);
    chk("mid_len16", 32'(n16), 32'd16);
    chk("mid_novld", 32'(vcnt), 32'd0);
    rd16(4'd0, 2'b00, "mid_a0");
    rd16(4'd3, 2'b00, "mid_a3");

`ifdef SYN_RAM_PARITY_EN
    bus16.par_inj = 1'b1;
    wr16(4'd2, 2'b11);
    bus16.par_inj = 1'b0;
    wr16(4'd4, 2'b01);
    rd16(4'd2, 2'b11, "par_a2");
    chk("par_err2", 32'(bus16.par_err), 32'd1);
    rd16(4'd4, 2'b01, "par_a4");
    chk("par_err4", 32'(bus16.par_err), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
